arf_mem_sequencer: RTL
======================

// Module: arf_mem_sequencer
// PURPOSE
//  Memory-side partner of the address register file: selects PC or AR as the address source,
//  performs a 16-bit access as two byte accesses to 8-bit synchronous memory (little-endian),
//  and, for instruction fetch, commands the register file to increment PC once per byte.
//  Sits between the control unit (Start/Op), the address register file and data memory.
// PARAMETERS
//  ADDR_W    16      address width (OutD / MemAddr)
//  SEL_PC    2'b01   OutDSel code selecting PC
//  SEL_AR    2'b10   OutDSel code selecting AR
// PORTS
//  Clock       in   1   system clock, all state on rising edge
//  Reset       in   1   asynchronous, active-high reset
//  Start       in   1   request, sampled only in IDLE
//  Op          in   2   00 FETCH (PC, PC+=2), 01 LOAD (AR), 10 STORE (AR), 11 reserved (ignored)
//  DataIn      in   16  store data, sampled with Start
//  ArfOutD     in   16  register file OutD (registered there: valid one cycle after OutDSel)
//  ArfOutDSel  out  2   OutD source select to register file
//  ArfFunSel   out  3   register function code to register file
//  ArfRegSel   out  3   active-low enables: bit0 SP, bit1 AR, bit2 PC; 3'b111 = no change
//  MemAddr     out  16  byte address
//  MemCS       out  1   memory chip select
//  MemWE       out  1   write enable (with MemCS)
//  MemWrData   out  8   write byte
//  MemRdData   in   8   read byte, valid the cycle after the address cycle
//  DataOut     out  16  assembled read word {hi,lo}, held until next read completes
//  Busy        out  1   high in every state except IDLE
//  Done        out  1   one-cycle completion pulse
// BEHAVIOUR
//  Reset (async): state=IDLE; DataOut=0, MemAddr=0, MemWrData=0, MemCS=0, MemWE=0, Done=0,
//   Busy=0, ArfOutDSel=SEL_PC, ArfFunSel=3'b000, ArfRegSel=3'b111. Reset mid-operation aborts;
//   no further memory or register-file command is issued; PC keeps whatever increments already occurred.
//  States: IDLE -> SEL -> ADDR -> LO -> HI -> CAP -> DONE -> IDLE (fixed 6 cycles after Start edge).
//  IDLE: Start=1 & Op!=11 -> latch Op, DataIn; drive ArfOutDSel (PC for FETCH, else AR) -> SEL.
//   Start with Op=11 ignored (stay IDLE, no Done). Start while Busy ignored.
//  SEL:  wait one cycle for registered ArfOutD.
//  ADDR: latch Base=ArfOutD.
//  LO:   MemAddr=Base, MemCS=1, MemWE=(STORE), MemWrData=DataIn[7:0];
//        FETCH: ArfRegSel=3'b011, ArfFunSel=FUN_INC (PC+1).
//  HI:   MemAddr=Base+1 (mod 2^16, 16'hFFFF wraps to 16'h0000), MemWrData=DataIn[15:8];
//        capture MemRdData into lo byte (reads); FETCH: second PC increment.
//  CAP:  MemCS=0; capture MemRdData into hi byte (reads); ArfRegSel=3'b111.
//  DONE: Done=1 for exactly one cycle; DataOut updated (LOAD/FETCH only, STORE leaves it unchanged) -> IDLE.
//  Outside LO/HI: MemCS=0, MemWE=0, ArfRegSel=3'b111. LOAD/STORE never modify AR, SP or PC.
//  ArfOutDSel held stable from SEL through DONE.
// STRUCTURE
//  Shared package: FunSel codes (FUN_DEC=3'b000, FUN_INC=3'b001), OutDSel codes, Op codes,
//   RegSel active-low masks (REGSEL_NONE=3'b111, REGSEL_PC=3'b011, REGSEL_AR=3'b101, REGSEL_SP=3'b110),
//   state enum.
//  Single module; no sub-module (byte assembly is two 8-bit registers).
// TESTING
//  Reset: assert Reset mid-HI -> immediately Busy=0, MemCS=0, ArfRegSel=3'b111; Done never pulses.
//  FETCH: PC=16'h0010, mem[10]=8'h34, mem[11]=8'h12 -> DataOut=16'h1234, PC=16'h0012, Done 6 cycles after Start.
//  LOAD: AR=16'h0200, mem[200]=8'hCD, mem[201]=8'hAB -> DataOut=16'hABCD; PC, AR, SP unchanged.
//  STORE: AR=16'h0300, DataIn=16'hBEEF -> mem[300]=8'hEF, mem[301]=8'hBE; DataOut unchanged.
//  Wrap: LOAD with AR=16'hFFFF -> HI-cycle MemAddr=16'h0000; DataOut={mem[0000],mem[FFFF]}.
//  Ignore: Start during Busy, and Op=2'b11 in IDLE -> no memory access, no extra Done pulse.

Source files
------------

// File: rtl/arf_mem_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// arf_mem_sequencer_pkg
// Purpose: shared constants and types for the address-register-file memory
//          sequencer. It holds the register-file function codes, the OutD
//          source selects, the active-low register enable masks, the
//          operation codes and the sequencer state encoding.
// Ports:   none (package)
// ---------------------------------------------------------------------------
package arf_mem_sequencer_pkg;

    localparam int ADDR_W = 16;

    // OutD source selects understood by the address register file
    localparam logic [1:0] SEL_PC = 2'b01;
    localparam logic [1:0] SEL_AR = 2'b10;

    // Register file function codes
    localparam logic [2:0] FUN_DEC = 3'b000;
    localparam logic [2:0] FUN_INC = 3'b001;

    // Active-low register enables: bit0 SP, bit1 AR, bit2 PC
    localparam logic [2:0] REGSEL_NONE = 3'b111;
    localparam logic [2:0] REGSEL_PC   = 3'b011;
    localparam logic [2:0] REGSEL_AR   = 3'b101;
    localparam logic [2:0] REGSEL_SP   = 3'b110;

    typedef enum logic [1:0] {
        OP_FETCH = 2'b00,
        OP_LOAD  = 2'b01,
        OP_STORE = 2'b10,
        OP_RSVD  = 2'b11
    } seqOp_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SEL  = 3'd1,
        ST_ADDR = 3'd2,
        ST_LO   = 3'd3,
        ST_HI   = 3'd4,
        ST_CAP  = 3'd5,
        ST_DONE = 3'd6
    } seqState_t;

    // Address of the upper byte of a word; wraps naturally at 16'hFFFF
    function automatic logic [ADDR_W-1:0] nextByteAddr(input logic [ADDR_W-1:0] addr);
        return addr + {{(ADDR_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/arf_mem_sequencer_if.sv
// ---------------------------------------------------------------------------
// arf_mem_sequencer_if
// Purpose: bundles every signal the sequencer exchanges with the control
//          unit, the address register file and byte-wide data memory.
// Signals:
//   start, op, dataIn          control unit request and store data
//   arfOutD                    registered OutD from the register file
//   arfOutDSel/FunSel/RegSel   commands to the register file
//   memAddr/CS/WE/WrData       byte memory command
//   memRdData                  byte read data (one cycle after address)
//   dataOut, busy, done        result word and status to the control unit
// Modports:
//   slave  - the sequencer itself
//   master - the surrounding system (control unit, register file, memory)
// ---------------------------------------------------------------------------
interface arf_mem_sequencer_if;
    import arf_mem_sequencer_pkg::*;

    logic              start;
    logic [1:0]        op;
    logic [15:0]       dataIn;
    logic [ADDR_W-1:0] arfOutD;
    logic [1:0]        arfOutDSel;
    logic [2:0]        arfFunSel;
    logic [2:0]        arfRegSel;
    logic [ADDR_W-1:0] memAddr;
    logic              memCS;
    logic              memWE;
    logic [7:0]        memWrData;
    logic [7:0]        memRdData;
    logic [15:0]       dataOut;
    logic              busy;
    logic              done;

    modport slave (
        input  start, op, dataIn, arfOutD, memRdData,
        output arfOutDSel, arfFunSel, arfRegSel,
               memAddr, memCS, memWE, memWrData,
               dataOut, busy, done
    );

    modport master (
        output start, op, dataIn, arfOutD, memRdData,
        input  arfOutDSel, arfFunSel, arfRegSel,
               memAddr, memCS, memWE, memWrData,
               dataOut, busy, done
    );

endinterface

// File: rtl/arf_mem_sequencer.sv
// ---------------------------------------------------------------------------
// arf_mem_sequencer
// Purpose: memory-side partner of the address register file. Picks PC or AR
//          as the address source, performs a 16-bit access as two
//          little-endian byte accesses to synchronous 8-bit memory, and on
//          instruction fetch tells the register file to bump PC once per byte.
//          Every operation takes a fixed six busy cycles:
//          SEL, ADDR, LO, HI, CAP, DONE.
// Ports:
//   clk  in   system clock, all state on the rising edge
//   rst  in   asynchronous active-high reset
//   bus  slave modport of arf_mem_sequencer_if (request, register file
//        commands, memory commands, result and status)
// ---------------------------------------------------------------------------
module arf_mem_sequencer
    import arf_mem_sequencer_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    arf_mem_sequencer_if.slave bus
);

    seqState_t         state_q,     state_d;
    seqOp_t            op_q,        op_d;
    logic [15:0]       dataIn_q,    dataIn_d;
    logic [ADDR_W-1:0] base_q,      base_d;
    logic [7:0]        lo_q,        lo_d;
    logic [15:0]       dataOut_q,   dataOut_d;
    logic [1:0]        outDSel_q,   outDSel_d;
    logic [2:0]        funSel_q,    funSel_d;
    logic [2:0]        regSel_q,    regSel_d;
    logic [ADDR_W-1:0] memAddr_q,   memAddr_d;
    logic              memCS_q,     memCS_d;
    logic              memWE_q,     memWE_d;
    logic [7:0]        memWrData_q, memWrData_d;

    logic isStore;
    logic isFetch;

    assign isStore = (op_q == OP_STORE);
    assign isFetch = (op_q == OP_FETCH);

    // State and all outward commands are registered so that every output has
    // a clean reset value and an abort by reset silences memory and the
    // register file in the same instant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_FETCH;
            dataIn_q    <= '0;
            base_q      <= '0;
            lo_q        <= '0;
            dataOut_q   <= '0;
            outDSel_q   <= SEL_PC;
            funSel_q    <= FUN_DEC;
            regSel_q    <= REGSEL_NONE;
            memAddr_q   <= '0;
            memCS_q     <= 1'b0;
            memWE_q     <= 1'b0;
            memWrData_q <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            dataIn_q    <= dataIn_d;
            base_q      <= base_d;
            lo_q        <= lo_d;
            dataOut_q   <= dataOut_d;
            outDSel_q   <= outDSel_d;
            funSel_q    <= funSel_d;
            regSel_q    <= regSel_d;
            memAddr_q   <= memAddr_d;
            memCS_q     <= memCS_d;
            memWE_q     <= memWE_d;
            memWrData_q <= memWrData_d;
        end
    end

    // Next-state and next-command logic. Each state computes the commands
    // that must be visible during the following state, because outputs are
    // registered: ADDR sets up the LO byte access straight from ArfOutD
    // (the same value latched as the base), LO sets up the HI access, and so
    // on. Memory chip select and PC increments default to off so they are
    // only ever asserted for the LO and HI cycles.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        dataIn_d    = dataIn_q;
        base_d      = base_q;
        lo_d        = lo_q;
        dataOut_d   = dataOut_q;
        outDSel_d   = outDSel_q;
        funSel_d    = FUN_DEC;
        regSel_d    = REGSEL_NONE;
        memAddr_d   = memAddr_q;
        memCS_d     = 1'b0;
        memWE_d     = 1'b0;
        memWrData_d = memWrData_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start && (bus.op != OP_RSVD)) begin
                    op_d      = seqOp_t'(bus.op);
                    dataIn_d  = bus.dataIn;
                    outDSel_d = (bus.op == OP_FETCH) ? SEL_PC : SEL_AR;
                    state_d   = ST_SEL;
                end
            end
            ST_SEL: begin
                state_d = ST_ADDR;
            end
            ST_ADDR: begin
                base_d      = bus.arfOutD;
                memAddr_d   = bus.arfOutD;
                memCS_d     = 1'b1;
                memWE_d     = isStore;
                memWrData_d = dataIn_q[7:0];
                if (isFetch) begin
                    regSel_d = REGSEL_PC;
                    funSel_d = FUN_INC;
                end
                state_d = ST_LO;
            end
            ST_LO: begin
                memAddr_d   = nextByteAddr(base_q);
                memCS_d     = 1'b1;
                memWE_d     = isStore;
                memWrData_d = dataIn_q[15:8];
                if (isFetch) begin
                    regSel_d = REGSEL_PC;
                    funSel_d = FUN_INC;
                end
                state_d = ST_HI;
            end
            ST_HI: begin
                if (!isStore) begin
                    lo_d = bus.memRdData;
                end
                state_d = ST_CAP;
            end
            ST_CAP: begin
                if (!isStore) begin
                    dataOut_d = {bus.memRdData, lo_q};
                end
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.arfOutDSel = outDSel_q;
    assign bus.arfFunSel  = funSel_q;
    assign bus.arfRegSel  = regSel_q;
    assign bus.memAddr    = memAddr_q;
    assign bus.memCS      = memCS_q;
    assign bus.memWE      = memWE_q;
    assign bus.memWrData  = memWrData_q;
    assign bus.dataOut    = dataOut_q;
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.done       = (state_q == ST_DONE);

endmodule
